// File: rtl/b16_to_bcd.sv
// 16-bit unsigned binary to five-digit BCD converter with registered outputs.
// A cleared enable loads the blank code into every digit.
module b16_to_bcd (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] to_display,
    input  logic        enable,
    output logic [3:0]  D5,
    output logic [3:0]  D4,
    output logic [3:0]  D3,
    output logic [3:0]  D2,
    output logic [3:0]  D1
);

    localparam int unsigned NumDigits = 5;
    localparam int unsigned BinWidth  = 16;
    localparam int unsigned BcdWidth  = 4 * NumDigits;
    localparam logic [3:0]  BlankCode = 4'hF;

    // Shift-add-3 correction for one BCD column.
    function automatic logic [3:0] add3(input logic [3:0] col);
        return (col >= 4'd5) ? col + 4'd3 : col;
    endfunction

    logic [BcdWidth-1:0] bcd;
    logic [BcdWidth-1:0] digits_d;
    logic [BcdWidth-1:0] digits_q;

    // Double dabble: BCD scratch sits above the binary bits and both shift left together.
    always_comb begin
        logic [BcdWidth+BinWidth-1:0] scratch;
        scratch = {{BcdWidth{1'b0}}, to_display};
        for (int i = 0; i < BinWidth; i++) begin
            for (int c = 0; c < NumDigits; c++) begin
                scratch[BinWidth + 4*c +: 4] = add3(scratch[BinWidth + 4*c +: 4]);
            end
            scratch = scratch << 1;
        end
        bcd = scratch[BinWidth +: BcdWidth];
    end

    always_comb begin
        digits_d = enable ? bcd : {NumDigits{BlankCode}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q <= '0;
        end else begin
            digits_q <= digits_d;
        end
    end

    assign D5 = digits_q[19:16];
    assign D4 = digits_q[15:12];
    assign D3 = digits_q[11:8];
    assign D2 = digits_q[7:4];
    assign D1 = digits_q[3:0];

endmodule

// File: tb/tb_b16_to_bcd.sv
// Self-checking bench for b16_to_bcd: directed cases, exhaustive sweep and
// randomized traffic against a division-based reference model.
module tb_b16_to_bcd;

    logic        clk;
    logic        rst;
    logic [15:0] to_display;
    logic        enable;
    logic [3:0]  D5, D4, D3, D2, D1;
    logic [19:0] dout;

    int checks = 0;
    int errors = 0;

    b16_to_bcd dut (
        .clk        (clk),
        .rst        (rst),
        .to_display (to_display),
        .enable     (enable),
        .D5         (D5),
        .D4         (D4),
        .D3         (D3),
        .D2         (D2),
        .D1         (D1)
    );

    assign dout = {D5, D4, D3, D2, D1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by integer division, or the blank pattern.
    function automatic logic [19:0] model(input int unsigned v, input logic en);
        logic [19:0] r;
        if (!en) return 20'hFFFFF;
        r[19:16] = 4'(v / 10000);
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Drive inputs mid-cycle, then sample just after the next rising edge.
    task automatic step(input logic [15:0] v, input logic en, input logic r);
        @(negedge clk);
        to_display = v;
        enable     = en;
        rst        = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(16'd12345, 1'b1, 1'b1);
        checks++;
        if (dout !== 20'h00000) begin
            errors++;
            $display("FAIL reset_cycle1: got %h want %h", dout, 20'h00000);
        end
        step(16'd12345, 1'b1, 1'b1);
        checks++;
        if (dout !== 20'h00000) begin
            errors++;
            $display("FAIL reset_cycle2: got %h want %h", dout, 20'h00000);
        end
        step(16'd12345, 1'b1, 1'b0);
        checks++;
        if (dout !== 20'h12345) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", dout, 20'h12345);
        end
    endtask

    task automatic test_nominal_blank();
        step(16'd58039, 1'b1, 1'b0);
        checks++;
        if (dout !== 20'h58039) begin
            errors++;
            $display("FAIL nominal: got %h want %h", dout, 20'h58039);
        end
        step(16'd58039, 1'b0, 1'b0);
        checks++;
        if (dout !== 20'hFFFFF) begin
            errors++;
            $display("FAIL blank: got %h want %h", dout, 20'hFFFFF);
        end
        step(16'd58039, 1'b1, 1'b0);
        checks++;
        if (dout !== 20'h58039) begin
            errors++;
            $display("FAIL unblank: got %h want %h", dout, 20'h58039);
        end
    endtask

    task automatic test_directed();
        int unsigned vals[8] = '{32, 0, 9, 10, 65535, 9999, 10000, 59999};
        logic [19:0] want[8] = '{20'h00032, 20'h00000, 20'h00009, 20'h00010,
                                 20'h65535, 20'h09999, 20'h10000, 20'h59999};
        for (int i = 0; i < 8; i++) begin
            step(16'(vals[i]), 1'b1, 1'b0);
            checks++;
            if (dout !== want[i]) begin
                errors++;
                $display("FAIL directed_%0d: got %h want %h", vals[i], dout, want[i]);
            end
        end
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 65536; v++) begin
            step(16'(v), 1'b1, 1'b0);
            checks++;
            if (dout !== model(v, 1'b1)) begin
                errors++;
                $display("FAIL sweep_%0d: got %h want %h", v, dout, model(v, 1'b1));
            end
            checks++;
            if (D5 > 4'd6 || D4 > 4'd9 || D3 > 4'd9 || D2 > 4'd9 || D1 > 4'd9) begin
                errors++;
                $display("FAIL range_%0d: got %h want digits<=9, D5<=6", v, dout);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            logic [15:0] v;
            logic        en;
            v  = 16'($urandom);
            en = ($urandom_range(0, 3) != 0);
            step(v, en, 1'b0);
            checks++;
            if (dout !== model(v, en)) begin
                errors++;
                $display("FAIL b2b_%0d: in %0d en %0b got %h want %h", i, v, en, dout,
                         model(v, en));
            end
        end
    endtask

    task automatic test_glitch();
        logic [19:0] held;
        step(16'd4321, 1'b1, 1'b0);
        held = model(4321, 1'b1);
        // Change inputs between edges; outputs must not follow.
        to_display = 16'd777;
        enable     = 1'b0;
        #2;
        checks++;
        if (dout !== held) begin
            errors++;
            $display("FAIL glitch: got %h want %h", dout, held);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dout !== 20'hFFFFF) begin
            errors++;
            $display("FAIL glitch_next_edge: got %h want %h", dout, 20'hFFFFF);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 20; i++) begin
            logic [15:0] v;
            logic        en;
            v  = 16'($urandom);
            en = $urandom_range(0, 1) == 1;
            step(v, en, 1'b0);
            step(16'($urandom), 1'b0, 1'b1);
            checks++;
            if (dout !== 20'h00000) begin
                errors++;
                $display("FAIL midreset_%0d: got %h want %h", i, dout, 20'h00000);
            end
            step(v, en, 1'b0);
            checks++;
            if (dout !== model(v, en)) begin
                errors++;
                $display("FAIL midreset_release_%0d: got %h want %h", i, dout, model(v, en));
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b1;
        to_display = 16'd0;
        test_reset();
        test_nominal_blank();
        test_directed();
        test_glitch();
        test_sweep();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
